// File: rtl/pc_sequencer.sv
// Program counter with call/return/interrupt stack; one action per clk edge, new ROMaddr visible next cycle.
// stall freezes every register (int_ack drops to 0); rst overrides stall and all requests.
module pc_sequencer #(
  parameter int          DEPTH      = 8,
  parameter logic [15:0] RESET_ADDR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        PCpp,
  input  logic        jmp,
  input  logic        call,
  input  logic [15:0] jmp_addr,
  input  logic        Ret,
  input  logic        INTjmp,
  input  logic [15:0] int_vector,
  output logic [15:0] ROMaddr,
  output logic        int_active,
  output logic        int_ack,
  output logic        stack_full,
  output logic        stack_empty,
  output logic        stack_err
);
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int AW = PW - 1;

  logic [16:0]   stack_q [DEPTH];
  logic [PW-1:0] cnt_q, cnt_d;
  logic [15:0]   pc_q, pc_d;
  logic          act_q, act_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic          push_en;
  logic [16:0]   push_dat;
  logic [AW-1:0] top_idx;
  logic [16:0]   top_dat;
  logic          full, empty;

  assign full    = (cnt_q == PW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign top_idx = cnt_q[AW-1:0] - AW'(1);
  assign top_dat = stack_q[top_idx];

  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    ack_d    = 1'b0;
    err_d    = err_q;
    push_en  = 1'b0;
    push_dat = '0;
    if (!stall) begin
      // An interrupt that cannot be taken falls through to the other requests.
      if (INTjmp && !act_q && !full) begin
        push_en  = 1'b1;
        push_dat = {1'b1, pc_q};
        pc_d     = int_vector;
        cnt_d    = cnt_q + PW'(1);
        act_d    = 1'b1;
        ack_d    = 1'b1;
      end else if (Ret) begin
        if (empty) begin
          err_d = 1'b1;
        end else begin
          pc_d  = top_dat[15:0];
          cnt_d = cnt_q - PW'(1);
          if (top_dat[16]) act_d = 1'b0;
        end
      end else if (call) begin
        if (full) begin
          err_d = 1'b1;
        end else begin
          push_en  = 1'b1;
          push_dat = {1'b0, pc_q + 16'd1};
          pc_d     = jmp_addr;
          cnt_d    = cnt_q + PW'(1);
        end
      end else if (jmp) begin
        pc_d = jmp_addr;
      end else if (PCpp) begin
        pc_d = pc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_ADDR;
      cnt_q <= '0;
      act_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
      act_q <= act_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  // Entry storage carries no reset; only the count defines valid contents.
  always_ff @(posedge clk) begin
    if (!rst && push_en) stack_q[cnt_q[AW-1:0]] <= push_dat;
  end

  assign ROMaddr     = pc_q;
  assign int_active  = act_q;
  assign int_ack     = ack_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameters SHALL be one per line: name, default, meaning.
- DEPTH, 8, return-stack entries, power of two, 2..16.
- RESET_ADDR, 16'h0000, ROMaddr value after reset.
REQ-002 Ports SHALL be one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, synchronous active-high reset.
- stall, in, 1, freeze all state this cycle.
- PCpp, in, 1, advance PC by 1.
- jmp, in, 1, load PC from jmp_addr.
- call, in, 1, push ROMaddr+1, then load PC from jmp_addr.
- jmp_addr, in, 16, jump/call target.
- Ret, in, 1, pop return stack into PC.
- INTjmp, in, 1, interrupt request.
- int_vector, in, 16, interrupt target.
- ROMaddr, out, 16, current program address (registered).
- int_active, out, 1, interrupt handler in progress.
- int_ack, out, 1, one-cycle pulse when an interrupt is taken.
- stack_full, out, 1, stack holds DEPTH entries.
- stack_empty, out, 1, stack holds 0 entries.
- stack_err, out, 1, sticky overflow/underflow flag.

Function
REQ-003 The block SHALL update ROMaddr and the stack only on rising clk edges.
REQ-004 When stall=1 and rst=0, all state SHALL hold, and int_ack SHALL be 0.
REQ-005 One action per cycle SHALL be selected by fixed priority: INT > Ret > call > jmp > PCpp > hold.
REQ-006 INT SHALL be taken only when INTjmp=1, int_active=0 and stack_full=0; an INTjmp that is not taken SHALL be ignored rather than queued, and evaluation falls through to lower-priority actions.
REQ-007 Taking INT SHALL:
- push {tag=1, ROMaddr};
- load ROMaddr=int_vector;
- set int_active=1;
- pulse int_ack=1 for exactly one cycle.
REQ-008 call SHALL push {tag=0, ROMaddr+1 mod 2^16} and load ROMaddr=jmp_addr.
REQ-009 Ret SHALL pop the top entry into ROMaddr; if the popped tag=1, int_active SHALL clear in the same edge.
REQ-010 jmp SHALL load ROMaddr=jmp_addr with no stack change.
REQ-011 PCpp SHALL increment ROMaddr modulo 2^16, so 16'hFFFF wraps to 16'h0000.
REQ-012 Latency: the new ROMaddr SHALL be visible the cycle after the action edge.
REQ-013 Stack: LIFO with a pointer of clog2(DEPTH)+1 bits.
- stack_full SHALL equal (count==DEPTH).
- stack_empty SHALL equal (count==0).
- Both flags SHALL be registered-consistent with count.
REQ-014 A call with stack_full=1 SHALL:
- leave ROMaddr and the stack unchanged;
- set stack_err=1.
REQ-015 A Ret with stack_empty=1 SHALL:
- leave ROMaddr and the stack unchanged;
- set stack_err=1.
REQ-016 Once set, stack_err SHALL remain 1 until rst.
REQ-017 A lower-priority request presented with a higher-priority one in the same cycle SHALL be discarded, not deferred.
REQ-018 Stack entries SHALL be 17 bits each: tag plus address.
REQ-019 Entry contents need no reset; only the count pointer is reset.

Reset
REQ-020 When rst=1 at a clock edge, the block SHALL set:
- ROMaddr=RESET_ADDR;
- count=0, stack_empty=1, stack_full=0;
- int_active=0, int_ack=0, stack_err=0.
REQ-021 rst SHALL override stall and every request.
REQ-022 rst asserted mid-interrupt or mid-call SHALL discard all stack contents.

Verification
REQ-023 A bench SHALL cover these directed scenarios.
- Reset then 3×PCpp -> ROMaddr 0000,0001,0002,0003; stack_empty=1.
- ROMaddr=0010, call jmp_addr=0100 -> ROMaddr=0100, count=1. Then Ret -> ROMaddr=0011, stack_empty=1.
- ROMaddr=0020, INTjmp+PCpp+jmp same cycle, int_vector=0200 -> ROMaddr=0200, int_ack pulses 1 cycle, int_active=1. Then Ret -> ROMaddr=0020, int_active=0.
- INTjmp held while int_active=1, jmp_addr=0300 with jmp=1 -> jmp taken (ROMaddr=0300), no second int_ack, int_active stays 1.
- DEPTH=8: 8 calls -> stack_full=1. 9th call -> ROMaddr unchanged, stack_err=1. 8 Ret -> empty. Extra Ret -> ROMaddr unchanged, stack_err stays 1 until rst.
- ROMaddr=FFFF, PCpp with stall=1 -> FFFF held. Then stall=0 -> 0000. Then rst with call=1 -> ROMaddr=RESET_ADDR, count=0.
